calc_core: RTL and testbench

Operand-entry and arithmetic stage of the two-function calculator. It sits directly upstream of the display output unit. Operands are entered on the switches, and each press of the ENTER key accepts one value. The block adds or subtracts the two operands and drives an 8-bit two's-complement RESULT that the display unit converts to sign plus three decimal digits. It also flags signed overflow.

---
 rtl/calc_pkg.sv | 16 +
 rtl/key_conditioner.sv | 76 +++++++
 rtl/calc_core.sv | 134 +++++++++++++
 tb/tb_calc_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator core
package calc_pkg;

    localparam int N = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_SHOW = 2'd3
    } state_e;

endpackage

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - ENTER synchroniser, debouncer and press pulse
module key_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   level_q, level_d;
    logic                   armed_q, armed_d;
    logic                   pulse_q, pulse_d;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign pulse_o = pulse_q;

    // Debounce the synced level; a key found held after reset stays disarmed
    // until it has been seen released, so it cannot fire a press on its own.
    always_comb begin
        cnt_d     = '0;
        arm_cnt_d = '0;
        level_d   = level_q;
        armed_d   = armed_q;
        pulse_d   = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced;
                pulse_d = synced && armed_q;
                if (!synced) begin
                    armed_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (!armed_q && !synced && !level_q) begin
            if (arm_cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain and debounce state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            arm_cnt_q <= '0;
            level_q   <= 1'b0;
            armed_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q[0] <= key_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cnt_q     <= cnt_d;
            arm_cnt_q <= arm_cnt_d;
            level_q   <= level_d;
            armed_q   <= armed_d;
            pulse_q   <= pulse_d;
        end
    end

endmodule

// File: rtl/calc_core.sv
// rtl/calc_core.sv - operand entry FSM, add/subtract ALU and overflow flag
module calc_core #(
    parameter int N               = calc_pkg::N,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic [N-1:0] SW,
    input  logic         OP,
    input  logic         ENTER,
    output logic [N-1:0] RESULT,
    output logic         OVF,
    output logic [1:0]   STATE
);

    import calc_pkg::*;

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] r_q, r_d;
    logic         op_q, op_d;
    logic         ovf_q, ovf_d;
    logic [N-1:0] result_q, result_d;
    logic         ovf_out_q, ovf_out_d;
    logic         enter_pulse;
    logic [N-1:0] alu_r;
    logic         alu_ovf;

    key_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i   (CLOCK_50),
        .reset_i (RESET),
        .key_i   (ENTER),
        .pulse_o (enter_pulse)
    );

    // Modular add/subtract with signed overflow from the operand and result signs
    always_comb begin
        alu_r   = (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
        alu_ovf = 1'b0;
        if (op_q == OP_SUB) begin
            alu_ovf = (a_q[N-1] != b_q[N-1]) && (alu_r[N-1] != a_q[N-1]);
        end else begin
            alu_ovf = (a_q[N-1] == b_q[N-1]) && (alu_r[N-1] != a_q[N-1]);
        end
    end

    // Next state, operand capture, and output values chosen by the state being entered
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        op_d      = op_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        ovf_out_d = ovf_out_q;
        case (state_q)
            S_A: begin
                if (enter_pulse) begin
                    a_d     = SW;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (enter_pulse) begin
                    b_d     = SW;
                    op_d    = OP;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                r_d     = alu_r;
                ovf_d   = alu_ovf;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (enter_pulse) begin
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
        case (state_d)
            S_A, S_B: begin
                result_d  = SW;
                ovf_out_d = 1'b0;
            end
            S_CALC: begin
                ovf_out_d = 1'b0;
            end
            S_SHOW: begin
                result_d  = r_d;
                ovf_out_d = ovf_d;
            end
            default: begin
                result_d  = SW;
                ovf_out_d = 1'b0;
            end
        endcase
    end

    // State, operand and registered output storage
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            op_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            op_q      <= op_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign RESULT = result_q;
    assign OVF    = ovf_out_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_calc_core.sv
// tb/tb_calc_core.sv - self-checking bench for calc_core
module tb_calc_core;

    localparam int N = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] exp_r;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       op;
    logic       enter;
    logic [7:0] result;
    logic       ovf;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    calc_core #(
        .N               (N),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW       (sw),
        .OP       (op),
        .ENTER    (enter),
        .RESULT   (result),
        .OVF      (ovf),
        .STATE    (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_release();
        enter = 1'b1;
        tick(12);
        enter = 1'b0;
        tick(12);
    endtask

    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic o,
                         output logic [7:0] r, output logic v);
        int sa, sb, res;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        res = o ? (sa - sb) : (sa + sb);
        v   = (res > 127) || (res < -128);
        r   = res[7:0];
    endtask

    task automatic run_calc(input logic [7:0] a, input logic [7:0] b, input logic o,
                            input logic [7:0] er, input logic eo, input string name);
        int n;
        chk({name, "_in_a"}, {30'd0, state}, 0);
        sw = a;
        press_release();
        chk({name, "_in_b"}, {30'd0, state}, 1);
        sw = b;
        op = o;
        tick(1);
        chk({name, "_echo_b"}, {24'd0, result}, {24'd0, b});
        chk({name, "_echo_ovf"}, {31'd0, ovf}, 0);
        enter = 1'b1;
        n = 0;
        while (state == 2'd1 && n < 40) begin
            tick(1);
            n++;
        end
        chk({name, "_calc"}, {30'd0, state}, 2);
        tick(1);
        chk({name, "_show"}, {30'd0, state}, 3);
        chk({name, "_result"}, {24'd0, result}, {24'd0, er});
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        sw = ~b;
        op = ~o;
        tick(3);
        chk({name, "_hold_r"}, {24'd0, result}, {24'd0, er});
        chk({name, "_hold_ovf"}, {31'd0, ovf}, {31'd0, eo});
        enter = 1'b0;
        tick(12);
        chk({name, "_release"}, {30'd0, state}, 3);
        press_release();
        chk({name, "_wrap"}, {30'd0, state}, 0);
        chk({name, "_wrap_echo"}, {24'd0, result}, {24'd0, sw});
    endtask

    initial begin
        vec_t       vecs[9];
        logic [7:0] ra, rb, mr;
        logic       ro, mv;
        int         moved;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        vecs[1] = '{8'h03, 8'h0A, 1'b1, 8'hF9, 1'b0};
        vecs[2] = '{8'h64, 8'h32, 1'b0, 8'h96, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1};
        vecs[4] = '{8'h80, 8'h00, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b1};
        vecs[6] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        rst   = 1'b1;
        sw    = 8'h5A;
        op    = 1'b0;
        enter = 1'b0;
        tick(2);
        chk("reset_state", {30'd0, state}, 0);
        chk("reset_result", {24'd0, result}, 0);
        chk("reset_ovf", {31'd0, ovf}, 0);
        rst = 1'b0;
        tick(10);

        sw = 8'h11;
        tick(1);
        chk("echo_11", {24'd0, result}, 32'h11);
        sw = 8'h22;
        chk("echo_lag", {24'd0, result}, 32'h11);
        tick(1);
        chk("echo_22", {24'd0, result}, 32'h22);

        for (int i = 0; i < 9; i++) begin
            run_calc(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_r, vecs[i].exp_ovf,
                     $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ro = 1'($urandom_range(0, 1));
            model(ra, rb, ro, mr, mv);
            run_calc(ra, rb, ro, mr, mv, $sformatf("rnd%0d_%0h_%0h_%0d", i, ra, rb, ro));
        end

        for (int i = 0; i < 5; i++) begin
            enter = 1'b1;
            tick(2);
            enter = 1'b0;
            tick(2);
        end
        chk("bounce_rejected", {30'd0, state}, 0);
        enter = 1'b1;
        tick(10);
        chk("bounce_one_step", {30'd0, state}, 1);
        tick(10);
        chk("hold_no_repeat", {30'd0, state}, 1);
        enter = 1'b0;
        tick(12);
        chk("release_no_step", {30'd0, state}, 1);

        sw    = 8'h5A;
        enter = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("midreset_state", {30'd0, state}, 0);
        chk("midreset_result", {24'd0, result}, 0);
        chk("midreset_ovf", {31'd0, ovf}, 0);
        rst   = 1'b0;
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (state != 2'd0) moved++;
        end
        chk("held_through_reset", moved, 0);
        enter = 1'b0;
        tick(12);
        chk("release_after_reset", {30'd0, state}, 0);
        press_release();
        chk("press_after_reset", {30'd0, state}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
